// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// No logic, so no latency.
// No flow control of its own.
package uart_pkg;

  // Arbiter FSM states
  typedef enum logic [2:0] {
    ARB       = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    LOCKED    = 3'd4
  } arb_state_e;

  localparam int WORD_SIZE_DEF = 8;

  // Ceiling log2, usable in parameter expressions
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set bit of valid_i searching upward from ptr_i with wrap.
// Purely combinational, zero cycles.
// No backpressure; the caller decides whether the winner is served.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]        valid_i,
  input  logic [clog2(NUM_REQ)-1:0] ptr_i,
  output logic [clog2(NUM_REQ)-1:0] win_o,
  output logic                      any_o
);

  localparam int IDW = clog2(NUM_REQ);

  logic [IDW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest valid requester is written last and wins
  always_comb begin
    win_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(ptr_i) + k) % NUM_REQ);
      if (valid_i[cand]) begin
        any_o = 1'b1;
        win_o = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte producers, round-robin with frame lock and ack watchdog.
// Accept in cycle T gives tx_start in T+1; minimum turnaround 4 cycles plus transmitter busy time.
// req_ready is combinational and only offered in ARB/LOCKED while tx_busy is low; locked frames stall others.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WORD_SIZE   = WORD_SIZE_DEF,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*WORD_SIZE-1:0]  req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [WORD_SIZE-1:0]          tx_data_o,
  output logic                          tx_start_o,
  input  logic                          tx_busy_i,
  output logic [clog2(NUM_REQ)-1:0]     grant_id_o,
  output logic                          grant_active_o,
  output logic                          err_timeout_o
);

  localparam int IDW  = clog2(NUM_REQ);
  localparam int CNTW = 8;

  arb_state_e           state_q;
  logic [IDW-1:0]       rr_ptr_q;
  logic [IDW-1:0]       grant_id_q;
  logic                 locked_q;
  logic [WORD_SIZE-1:0] tx_data_q;
  logic                 tx_start_q;
  logic                 err_timeout_q;
  logic [CNTW-1:0]      cnt_q;
  logic [CNTW-1:0]      cnt_d;
  logic [IDW-1:0]       rr_ptr_d;

  logic [IDW-1:0]       win_idx;
  logic                 win_any;
  logic [IDW-1:0]       sel_idx;
  logic                 xfer;
  logic [WORD_SIZE-1:0] data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data_i[g*WORD_SIZE +: WORD_SIZE];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .valid_i (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .win_o   (win_idx),
    .any_o   (win_any)
  );

  // Next round-robin start is the requester after the last owner, wrapping explicitly for non-power-of-two counts
  assign rr_ptr_d = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);
  assign cnt_d    = cnt_q + CNTW'(1);
  assign sel_idx  = (state_q == LOCKED) ? grant_id_q : win_idx;
  assign xfer     = |req_ready_o;

  // Ready is one-hot: round-robin winner in ARB, only the lock owner in LOCKED, nothing while the transmitter is busy or in reset
  always_comb begin
    req_ready_o = '0;
    if (rst_ni && !tx_busy_i) begin
      if (state_q == ARB) begin
        if (win_any) req_ready_o[win_idx] = 1'b1;
      end else if (state_q == LOCKED) begin
        req_ready_o[grant_id_q] = req_valid_i[grant_id_q];
      end
    end
  end

  // Arbiter FSM with watchdog and registered transmitter-side outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ARB;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      locked_q      <= 1'b0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      tx_start_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      case (state_q)
        ARB, LOCKED: begin
          if (xfer) begin
            tx_data_q  <= data_arr[sel_idx];
            grant_id_q <= sel_idx;
            locked_q   <= ~req_last_i[sel_idx];
            tx_start_q <= 1'b1;
            state_q    <= START;
          end
        end
        START: begin
          cnt_q   <= '0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy_i) begin
            state_q <= WAIT_DONE;
          end else begin
            cnt_q <= cnt_d;
            // Transmitter never acknowledged: drop the byte and release any lock
            if (cnt_q == CNTW'(ACK_TIMEOUT - 1)) begin
              err_timeout_q <= 1'b1;
              locked_q      <= 1'b0;
              rr_ptr_q      <= rr_ptr_d;
              state_q       <= ARB;
            end
          end
        end
        WAIT_DONE: begin
          if (!tx_busy_i) begin
            if (locked_q) begin
              state_q <= LOCKED;
            end else begin
              rr_ptr_q <= rr_ptr_d;
              state_q  <= ARB;
            end
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign tx_data_o      = tx_data_q;
  assign tx_start_o     = tx_start_q;
  assign grant_id_o     = grant_id_q;
  assign grant_active_o = (state_q != ARB);
  assign err_timeout_o  = err_timeout_q;

endmodule
